// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle shift-add MUL/MLA sequencer with busy/done handshake
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             accumulate,
  input  logic             setflags,
  input  logic             flush,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] srcacc,
  input  logic [3:0]       flags_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       aluflags,
  output logic             flags_we
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, ACC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_l;
  logic [CW-1:0]    count;
  logic             accumulate_l;
  logic             setflags_l;

  logic [WIDTH-1:0] iter_sum;
  logic [WIDTH-1:0] acc_sum;
  logic             unused_flags;

  assign iter_sum     = product + (mplier[0] ? mcand : '0);
  assign acc_sum      = product + acc_l;
  // N and Z come from the product; only C and V are forwarded from flags_in.
  assign unused_flags = ^flags_in[3:2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      flags_we     <= 1'b0;
      result       <= '0;
      aluflags     <= 4'b0000;
      product      <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc_l        <= '0;
      count        <= '0;
      accumulate_l <= 1'b0;
      setflags_l   <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_we <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              mcand        <= srca;
              mplier       <= srcb;
              acc_l        <= srcacc;
              accumulate_l <= accumulate;
              setflags_l   <= setflags;
              product      <= '0;
              count        <= '0;
              state        <= ITER;
              busy         <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          ITER: begin
            product <= iter_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + 1'b1;
            if (count == LAST) begin
              if (accumulate_l) begin
                state <= ACC;
              end else begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                flags_we <= setflags_l;
                result   <= iter_sum;
                aluflags <= {iter_sum[WIDTH-1], iter_sum == '0, flags_in[1:0]};
              end
            end
          end
          ACC: begin
            product  <= acc_sum;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            flags_we <= setflags_l;
            result   <= acc_sum;
            aluflags <= {acc_sum[WIDTH-1], acc_sum == '0, flags_in[1:0]};
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed vector bench for mul_sequencer
module tb_mul_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        accumulate;
  logic        setflags;
  logic        flush;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] srcacc;
  logic [3:0]  flags_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  aluflags;
  logic        flags_we;

  int checks = 0;
  int fails  = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .accumulate(accumulate),
    .setflags(setflags), .flush(flush), .srca(srca), .srcb(srcb), .srcacc(srcacc),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result),
    .aluflags(aluflags), .flags_we(flags_we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic        mla;
    logic        sf;
    logic [3:0]  fin;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts on the next rising edge, then counts edges until done (bounded).
  task automatic run_op(input vec_t v, output int lat);
    @(negedge clock);
    srca = v.a; srcb = v.b; srcacc = v.acc;
    accumulate = v.mla; setflags = v.sf; flags_in = v.fin;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic wait_no_done(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{"mul_3x5",      32'd3,          32'd5,          32'd0, 1'b0, 1'b1, 4'b0011, 32'd15,         4'b0011, 1'b1, 32};
    vecs[1] = '{"mla_wrap",     32'hFFFFFFFF,   32'd2,          32'd3, 1'b1, 1'b1, 4'b0000, 32'h00000001,   4'b0000, 1'b1, 33};
    vecs[2] = '{"mul_zero_res", 32'h00010000,   32'h00010000,   32'd0, 1'b0, 1'b1, 4'b0000, 32'h00000000,   4'b0100, 1'b1, 32};
    vecs[3] = '{"mul_neg_nos",  32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 1'b0, 4'b0010, 32'hFFFFFFFF,   4'b1010, 1'b0, 32};
    vecs[4] = '{"mla_zero_mul", 32'h00001234,   32'd0,          32'd7, 1'b1, 1'b1, 4'b1111, 32'h00000007,   4'b0011, 1'b1, 33};
    vecs[5] = '{"mul_shift",    32'h00001234,   32'h00000010,   32'd0, 1'b0, 1'b1, 4'b0001, 32'h00012340,   4'b0001, 1'b1, 32};
    vecs[6] = '{"mul_signed",   32'hFFFFFFFD,   32'd7,          32'd0, 1'b0, 1'b1, 4'b0000, 32'hFFFFFFEB,   4'b1000, 1'b1, 32};
    vecs[7] = '{"mla_msb",      32'h40000000,   32'd2,          32'd0, 1'b1, 1'b1, 4'b0100, 32'h80000000,   4'b1000, 1'b1, 33};

    reset_n = 1'b0; start = 1'b0; accumulate = 1'b0; setflags = 1'b0; flush = 1'b0;
    srca = '0; srcb = '0; srcacc = '0; flags_in = 4'b0000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(flags_we), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(aluflags), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset mid-iteration: busy must drop without waiting for a clock edge.
    @(negedge clock);
    srca = 32'd9; srcb = 32'd9; accumulate = 1'b0; setflags = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy_async", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_no_done("midrst_no_done", 40);

    foreach (vecs[i]) begin
      run_op(vecs[i], lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_result"}, result, vecs[i].exp_result);
      chk({vecs[i].name, "_flags"}, 32'(aluflags), 32'(vecs[i].exp_flags));
      chk({vecs[i].name, "_we"}, 32'(flags_we), 32'(vecs[i].exp_we));
      chk({vecs[i].name, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk({vecs[i].name, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({vecs[i].name, "_result_hold"}, result, vecs[i].exp_result);
    end

    // start held high: ignored while busy, re-accepted in the DONE cycle.
    @(negedge clock);
    srca = 32'd3; srcb = 32'd5; srcacc = '0; accumulate = 1'b0; setflags = 1'b1;
    flags_in = 4'b0000; start = 1'b1;
    @(posedge clock); #1;
    srca = 32'd2; srcb = 32'd2;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 16) chk("held_busy_mid", 32'(busy), 32'd1);
    end
    chk("held_first_lat", 32'(lat), 32'd32);
    chk("held_first_result", result, 32'd15);
    lat = 0;
    @(posedge clock); #1;
    start = 1'b0;
    chk("held_reaccept_busy", 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("held_second_lat", 32'(lat), 32'd32);
    chk("held_second_result", result, 32'd4);
    chk("held_second_flags", 32'(aluflags), 32'b0000);

    // Flush at iteration 10: no done, result/flags retained.
    @(negedge clock);
    srca = 32'd7; srcb = 32'd9; setflags = 1'b1; flags_in = 4'b0011; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    wait_no_done("flush_no_done", 40);
    chk("flush_result_kept", result, 32'd4);
    chk("flush_flags_kept", 32'(aluflags), 32'b0000);

    // flush and start in the same cycle: flush wins.
    @(negedge clock);
    start = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_over_start_busy", 32'(busy), 32'd0);
    wait_no_done("flush_over_start_no_done", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
